// File: rtl/opfetch_if.sv
// Bundle of the operand-fetch stage's upstream, register-file, write-back and execute-side signals.
interface opfetch_if #(
   parameter int W = 32
);
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_insn;
   logic [31:0]   in_pc;
   logic          flush;
   logic          ren;
   logic [4:0]    rs1;
   logic [4:0]    rs2;
   logic [W-1:0]  rs1_val;
   logic [W-1:0]  rs2_val;
   logic          wen;
   logic [4:0]    rd;
   logic [W-1:0]  rd_val;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_insn;
   logic [31:0]   out_pc;
   logic [W-1:0]  out_rs1_val;
   logic [W-1:0]  out_rs2_val;

   modport slave (
      input  in_valid, in_insn, in_pc, flush, rs1_val, rs2_val,
             wen, rd, rd_val, out_ready,
      output in_ready, ren, rs1, rs2, out_valid, out_insn, out_pc,
             out_rs1_val, out_rs2_val
   );

   modport master (
      output in_valid, in_insn, in_pc, flush, rs1_val, rs2_val,
             wen, rd, rd_val, out_ready,
      input  in_ready, ren, rs1, rs2, out_valid, out_insn, out_pc,
             out_rs1_val, out_rs2_val
   );
endinterface

// File: rtl/opfetch.sv
// Operand-fetch stage: single slot that issues register-file reads and snoops
// write-back so held operands reflect writes the registered read cannot see.
module opfetch #(
   parameter int W = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   opfetch_if.slave   bus
);
   logic          out_valid_q, out_valid_d;
   logic [31:0]   out_insn_q, out_insn_d;
   logic [31:0]   out_pc_q, out_pc_d;
   logic [4:0]    h1_q, h1_d;
   logic [4:0]    h2_q, h2_d;
   logic          b1_q, b1_d;
   logic          b2_q, b2_d;
   logic [W-1:0]  v1_q, v1_d;
   logic [W-1:0]  v2_q, v2_d;
   logic          acc;
   logic [4:0]    rs1_idx;
   logic [4:0]    rs2_idx;
   logic          wr_live;

   assign rs1_idx = bus.in_insn[19:15];
   assign rs2_idx = bus.in_insn[24:20];
   assign wr_live = bus.wen && (bus.rd != 5'd0);

   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign acc          = bus.in_valid && bus.in_ready && !bus.flush;
   assign bus.ren      = acc;
   assign bus.rs1      = rs1_idx;
   assign bus.rs2      = rs2_idx;

   always_comb begin
      out_valid_d = out_valid_q;
      out_insn_d  = out_insn_q;
      out_pc_d    = out_pc_q;
      h1_d        = h1_q;
      h2_d        = h2_q;
      b1_d        = b1_q;
      b2_d        = b2_q;
      v1_d        = v1_q;
      v2_d        = v2_q;
      if (bus.flush) begin
         out_valid_d = 1'b0;
         b1_d        = 1'b0;
         b2_d        = 1'b0;
      end else if (acc) begin
         // A write in the accept cycle is invisible to the registered read, so capture it here.
         out_valid_d = 1'b1;
         out_insn_d  = bus.in_insn;
         out_pc_d    = bus.in_pc;
         h1_d        = rs1_idx;
         h2_d        = rs2_idx;
         b1_d        = wr_live && (bus.rd == rs1_idx);
         b2_d        = wr_live && (bus.rd == rs2_idx);
         if (wr_live && (bus.rd == rs1_idx)) v1_d = bus.rd_val;
         if (wr_live && (bus.rd == rs2_idx)) v2_d = bus.rd_val;
      end else begin
         if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
         if (out_valid_q && wr_live && (bus.rd == h1_q)) begin
            b1_d = 1'b1;
            v1_d = bus.rd_val;
         end
         if (out_valid_q && wr_live && (bus.rd == h2_q)) begin
            b2_d = 1'b1;
            v2_d = bus.rd_val;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_insn_q  <= '0;
         out_pc_q    <= '0;
         h1_q        <= '0;
         h2_q        <= '0;
         b1_q        <= 1'b0;
         b2_q        <= 1'b0;
         v1_q        <= '0;
         v2_q        <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_insn_q  <= out_insn_d;
         out_pc_q    <= out_pc_d;
         h1_q        <= h1_d;
         h2_q        <= h2_d;
         b1_q        <= b1_d;
         b2_q        <= b2_d;
         v1_q        <= v1_d;
         v2_q        <= v2_d;
      end
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.out_insn    = out_insn_q;
   assign bus.out_pc      = out_pc_q;
   assign bus.out_rs1_val = (!out_valid_q || h1_q == 5'd0) ? '0 : (b1_q ? v1_q : bus.rs1_val);
   assign bus.out_rs2_val = (!out_valid_q || h2_q == 5'd0) ? '0 : (b2_q ? v2_q : bus.rs2_val);
endmodule
